fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the five-stage RV32I pipeline. It sits directly upstream of decode and consumes the hazard unit's StallF, StallD and FlushD, plus the execute-stage redirect (br_sel and its target). It holds the fetch PC and drives a request/acknowledge instruction-memory port that tolerates wait states. It delivers {instruction, PC, PC+4, valid} to decode, inserting NOP bubbles on flushes and memory wait states.

---
 rtl/fetch_stage.sv | 137 +++++++++++++
 tb/tb_fetch_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register.
// Handles memory wait states, stalls, redirects and stale responses.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        br_sel,
  input  logic [31:0] pc_target,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc4_D,
  output logic        valid_D
);

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DROP
  } state_t;

  state_t      state;
  logic [31:0] pc_F;
  logic [31:0] drop_addr;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;

  logic        stall;
  logic        ack;
  logic        load;
  logic        bubble;
  logic [31:0] tgt;
  logic [31:0] ld_instr;
  logic [31:0] ld_pc;

  assign stall = StallF | StallD;
  assign tgt   = {pc_target[31:2], 2'b00};

  assign o_imem_req  = !i_rst && (state != HOLD);
  assign o_imem_addr = (state == DROP) ? drop_addr : pc_F;
  assign ack         = i_imem_ack & o_imem_req;

  always_comb begin
    load     = 1'b0;
    bubble   = 1'b0;
    ld_instr = i_imem_rdata;
    ld_pc    = pc_F;
    unique case (state)
      FETCH: begin
        if (br_sel)   bubble = !stall;
        else if (ack) load   = !stall;
        else          bubble = !stall;
      end
      HOLD: begin
        ld_instr = buf_instr;
        ld_pc    = buf_pc;
        if (br_sel) bubble = !stall;
        else        load   = !stall;
      end
      DROP:    bubble = !stall;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= FETCH;
      pc_F      <= RESET_PC;
      drop_addr <= RESET_PC;
      buf_instr <= NOP_INSTR;
      buf_pc    <= 32'd0;
    end else begin
      unique case (state)
        FETCH: begin
          if (br_sel) begin
            pc_F <= tgt;
            // in-flight word belongs to the old path
            if (!ack) begin
              drop_addr <= pc_F;
              state     <= DROP;
            end
          end else if (ack) begin
            pc_F <= pc_F + 32'd4;
            if (stall) begin
              buf_instr <= i_imem_rdata;
              buf_pc    <= pc_F;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (br_sel) begin
            pc_F  <= tgt;
            state <= FETCH;
          end else if (!stall) begin
            state <= FETCH;
          end
        end
        DROP: begin
          if (br_sel) pc_F <= tgt;
          if (ack)    state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || FlushD) begin
      instr_D <= NOP_INSTR;
      pc_D    <= 32'd0;
      pc4_D   <= 32'd0;
      valid_D <= 1'b0;
    end else if (!StallD) begin
      if (load) begin
        instr_D <= ld_instr;
        pc_D    <= ld_pc;
        pc4_D   <= ld_pc + 32'd4;
        valid_D <= 1'b1;
      end else if (bubble) begin
        instr_D <= NOP_INSTR;
        pc_D    <= 32'd0;
        pc4_D   <= 32'd0;
        valid_D <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: vector table,
// hand sequences and random traffic against a queue model.
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        sf, sd, fd, br;
  logic [31:0] tgt;
  logic        ack_ok;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;
  logic [31:0] instr_D, pc_D, pc4_D;
  logic        valid_D;

  assign ack   = ack_ok;
  assign rdata = addr ^ KEY;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .StallF      (sf),
    .StallD      (sd),
    .FlushD      (fd),
    .br_sel      (br),
    .pc_target   (tgt),
    .o_imem_req  (req),
    .o_imem_addr (addr),
    .i_imem_ack  (ack),
    .i_imem_rdata(rdata),
    .instr_D     (instr_D),
    .pc_D        (pc_D),
    .pc4_D       (pc4_D),
    .valid_D     (valid_D)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, a, e);
    end
  endtask

  // reference model: next address, parked words, stale request
  logic [31:0] m_pc;
  logic [31:0] park_w[$];
  logic [31:0] park_a[$];
  bit          stale;
  logic [31:0] stale_a;
  logic [31:0] m_instr, m_pcd, m_pc4;
  logic        m_vld;

  logic        req_s, ack_s;
  logic [31:0] addr_s;
  bit          prev_wait;
  logic [31:0] prev_addr;

  task automatic m_reset();
    m_pc = RPC;
    park_w.delete();
    park_a.delete();
    stale = 0;
    m_instr = NOP; m_pcd = 0; m_pc4 = 0; m_vld = 0;
  endtask

  task automatic cycle(input logic r, input logic a_sf,
                       input logic a_sd, input logic a_fd,
                       input logic a_br, input logic [31:0] a_t,
                       input logic a_ak);
    logic        ereq, am, stl, ld, bub;
    logic [31:0] eaddr, t, lw, lp;
    rst = r; sf = a_sf; sd = a_sd; fd = a_fd;
    br = a_br; tgt = a_t; ack_ok = a_ak;
    #1;
    ereq  = !r && (park_w.size() == 0);
    eaddr = stale ? stale_a : m_pc;
    chk("req", {31'd0, req}, {31'd0, ereq});
    if (ereq) chk("addr", addr, eaddr);
    if (prev_wait && !r) begin
      chk("wait_req", {31'd0, req}, 32'd1);
      chk("wait_addr", addr, prev_addr);
    end
    req_s = req; addr_s = addr;
    am = ereq & a_ak;
    ack_s = am;
    stl = a_sf | a_sd;
    t = a_t & 32'hFFFF_FFFC;
    ld = 0; bub = 0; lw = 0; lp = 0;
    if (r) begin
      m_reset();
    end else begin
      if (stale) begin
        if (am) stale = 0;
        if (a_br) m_pc = t;
        bub = !stl;
      end else if (park_w.size() != 0) begin
        if (a_br) begin
          park_w.delete(); park_a.delete();
          m_pc = t; bub = !stl;
        end else if (!stl) begin
          lw = park_w.pop_front();
          lp = park_a.pop_front();
          ld = 1;
        end
      end else if (a_br) begin
        if (!am) begin stale = 1; stale_a = m_pc; end
        m_pc = t; bub = !stl;
      end else if (am) begin
        if (stl) begin
          park_w.push_back(m_pc ^ KEY);
          park_a.push_back(m_pc);
        end else begin
          lw = m_pc ^ KEY; lp = m_pc; ld = 1;
        end
        m_pc = m_pc + 4;
      end else begin
        bub = !stl;
      end
      if (a_fd || (!a_sd && bub)) begin
        m_instr = NOP; m_pcd = 0; m_pc4 = 0; m_vld = 0;
      end else if (!a_sd && ld) begin
        m_instr = lw; m_pcd = lp; m_pc4 = lp + 4; m_vld = 1;
      end
    end
    prev_wait = !r && req_s && !am;
    prev_addr = addr_s;
    @(posedge clk);
    @(negedge clk);
    chk("instr_D", instr_D, m_instr);
    chk("pc_D", pc_D, m_pcd);
    chk("pc4_D", pc4_D, m_pc4);
    chk("valid_D", {31'd0, valid_D}, {31'd0, m_vld});
  endtask

  typedef struct {
    logic        sf, sd, fd, br;
    logic [31:0] tgt;
    logic        ak;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evld;
    logic [31:0] epc;
  } vec_t;

  vec_t tbl[19];

  initial begin
    int wcnt, nval;
    logic [31:0] ei, e4;
    tbl[0]  = '{0,0,0,0, 32'h0,   1, 1, 32'h100, 1, 32'h100};
    tbl[1]  = '{0,0,0,0, 32'h0,   1, 1, 32'h104, 1, 32'h104};
    tbl[2]  = '{1,1,0,0, 32'h0,   1, 1, 32'h108, 1, 32'h104};
    tbl[3]  = '{1,1,0,0, 32'h0,   1, 0, 32'h0,   1, 32'h104};
    tbl[4]  = '{1,1,0,0, 32'h0,   1, 0, 32'h0,   1, 32'h104};
    tbl[5]  = '{0,0,0,0, 32'h0,   1, 0, 32'h0,   1, 32'h108};
    tbl[6]  = '{0,0,0,0, 32'h0,   1, 1, 32'h10C, 1, 32'h10C};
    tbl[7]  = '{0,0,0,0, 32'h0,   0, 1, 32'h110, 0, 32'h0};
    tbl[8]  = '{0,0,1,1, 32'h200, 0, 1, 32'h110, 0, 32'h0};
    tbl[9]  = '{0,0,0,0, 32'h0,   1, 1, 32'h110, 0, 32'h0};
    tbl[10] = '{0,0,0,0, 32'h0,   1, 1, 32'h200, 1, 32'h200};
    tbl[11] = '{0,0,0,0, 32'h0,   1, 1, 32'h204, 1, 32'h204};
    tbl[12] = '{0,1,0,0, 32'h0,   1, 1, 32'h208, 1, 32'h204};
    tbl[13] = '{0,1,1,1, 32'h302, 1, 0, 32'h0,   0, 32'h0};
    tbl[14] = '{0,0,0,0, 32'h0,   1, 1, 32'h300, 1, 32'h300};
    tbl[15] = '{0,0,1,1, 32'hFFFF_FFF8, 1, 1, 32'h304, 0, 32'h0};
    tbl[16] = '{0,0,0,0, 32'h0, 1, 1, 32'hFFFF_FFF8,
                1, 32'hFFFF_FFF8};
    tbl[17] = '{0,0,0,0, 32'h0, 1, 1, 32'hFFFF_FFFC,
                1, 32'hFFFF_FFFC};
    tbl[18] = '{0,0,0,0, 32'h0, 1, 1, 32'h0, 1, 32'h0};

    rst = 1; sf = 0; sd = 0; fd = 0; br = 0;
    tgt = 0; ack_ok = 0; prev_wait = 0;
    m_reset();
    @(negedge clk);
    cycle(1, 0,0,0,0, 0, 1);
    cycle(1, 0,0,0,0, 0, 1);
    chk("rst_addr", addr, RPC);

    for (int i = 0; i < 19; i++) begin
      cycle(0, tbl[i].sf, tbl[i].sd, tbl[i].fd,
            tbl[i].br, tbl[i].tgt, tbl[i].ak);
      chk($sformatf("t%0d_req", i), {31'd0, req_s},
          {31'd0, tbl[i].ereq});
      if (tbl[i].ereq)
        chk($sformatf("t%0d_addr", i), addr_s, tbl[i].eaddr);
      ei = tbl[i].evld ? (tbl[i].epc ^ KEY) : NOP;
      e4 = tbl[i].evld ? (tbl[i].epc + 4) : 32'h0;
      chk($sformatf("t%0d_vld", i), {31'd0, valid_D},
          {31'd0, tbl[i].evld});
      chk($sformatf("t%0d_pc", i), pc_D, tbl[i].epc);
      chk($sformatf("t%0d_pc4", i), pc4_D, e4);
      chk($sformatf("t%0d_instr", i), instr_D, ei);
    end

    // two wait cycles per access
    wcnt = 0; nval = 0;
    for (int i = 0; i < 15; i++) begin
      cycle(0, 0,0,0,0, 0, wcnt >= 2);
      wcnt = (req_s && !ack_s) ? wcnt + 1 : 0;
      if (valid_D) nval++;
    end
    chk("lat2_count", nval, 5);

    // reset while a request is outstanding
    cycle(0, 0,0,0,0, 0, 0);
    cycle(1, 0,0,0,0, 0, 0);
    chk("mid_rst_req", {31'd0, req_s}, 32'd0);
    chk("mid_rst_instr", instr_D, NOP);
    chk("mid_rst_vld", {31'd0, valid_D}, 32'd0);
    cycle(0, 0,0,0,0, 0, 1);
    chk("post_rst_addr", addr_s, RPC);

    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 99) == 0,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 7) == 0,
            $urandom,
            $urandom_range(0, 2) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
